// File: rtl/cpu_pkg.sv
// cpu_pkg: shared HI/LO op encodings, controller states and decode helper.
package cpu_pkg;
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4
  } hilo_op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} hdc_state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/hilo_div_ctrl_if.sv
// hilo_div_ctrl_if: handshake between the HI/LO controller and the divider.
interface hilo_div_ctrl_if #(parameter int W = 32);
  logic         div_begin;
  logic         div_signed;
  logic [W-1:0] div_op1;
  logic [W-1:0] div_op2;
  logic [W-1:0] div_result;
  logic [W-1:0] div_remainder;
  logic         div_end;
  modport master(
    output div_begin, div_signed, div_op1, div_op2,
    input  div_result, div_remainder, div_end
  );
  modport slave(
    input  div_begin, div_signed, div_op1, div_op2,
    output div_result, div_remainder, div_end
  );
endinterface

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO with a divide-complete port and MTHI/MTLO ports.
module hilo_regs #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_div_we,
  input  logic [W-1:0] i_div_hi,
  input  logic [W-1:0] i_div_lo,
  input  logic         i_mt_hi_we,
  input  logic         i_mt_lo_we,
  input  logic [W-1:0] i_mt_data,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);
  logic [W-1:0] r_hi, r_lo;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_div_we) begin
        r_hi <= i_div_hi;
        r_lo <= i_div_lo;
      end
      if (i_mt_hi_we) r_hi <= i_mt_data;
      if (i_mt_lo_we) r_lo <= i_mt_data;
    end
  end
  assign o_hi = r_hi;
  assign o_lo = r_lo;
endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: issues DIV/DIVU to the divider, stalls EX while it runs, owns HI/LO.
module hilo_div_ctrl
  import cpu_pkg::*;
#(parameter int W = 32) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic [2:0]              ex_op,
  input  logic [W-1:0]            ex_rs,
  input  logic [W-1:0]            ex_rt,
  input  logic                    flush,
  output logic                    stall,
  output logic [W-1:0]            hi,
  output logic [W-1:0]            lo,
  hilo_div_ctrl_if.master         dv
);
  hdc_state_t   r_state, w_next;
  logic         r_begin, r_signed;
  logic [W-1:0] r_op1, r_op2;
  logic         w_idle_ok, w_issue, w_mt_hi, w_mt_lo, w_div_we;
  always_comb begin
    w_idle_ok = r_state == IDLE && ex_valid && !flush;
    w_issue   = w_idle_ok && is_div(ex_op);
    w_mt_hi   = w_idle_ok && ex_op == OP_MTHI;
    w_mt_lo   = w_idle_ok && ex_op == OP_MTLO;
    w_div_we  = r_state == BUSY && dv.div_end && !flush;
    w_next    = r_state == IDLE ? (w_issue ? BUSY : IDLE) :
                r_state == BUSY ? (flush ? IDLE : dv.div_end ? DONE : BUSY) : IDLE;
  end
  // operands hold from issue through DONE; the divider reads them live
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_begin  <= 1'b0;
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
    end else begin
      r_state <= w_next;
      r_begin <= w_next == BUSY;
      if (w_issue) begin
        r_op1    <= ex_rs;
        r_op2    <= ex_rt;
        r_signed <= ex_op == OP_DIV;
      end
    end
  end
  assign stall         = w_issue || r_state == BUSY;
  assign dv.div_begin  = r_begin;
  assign dv.div_signed = r_signed;
  assign dv.div_op1    = r_op1;
  assign dv.div_op2    = r_op2;
  hilo_regs #(.W(W)) u_regs (
    .clk        (clk),
    .rst        (rst),
    .i_div_we   (w_div_we),
    .i_div_hi   (dv.div_remainder),
    .i_div_lo   (dv.div_result),
    .i_mt_hi_we (w_mt_hi),
    .i_mt_lo_we (w_mt_lo),
    .i_mt_data  (ex_rs),
    .o_hi       (hi),
    .o_lo       (lo)
  );
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: directed checks of issue, stall, retire, flush and reset behaviour.
module tb_hilo_div_ctrl;
  import cpu_pkg::*;
  logic        clk = 1'b0;
  logic        rst, ex_valid, flush, stall;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs, ex_rt, hi, lo;
  logic [31:0] exp_hi, exp_lo;
  int          n_vec = 0, n_err = 0;
  hilo_div_ctrl_if #(.W(32)) u_if ();
  hilo_div_ctrl #(.W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_op    (ex_op),
    .ex_rs    (ex_rs),
    .ex_rt    (ex_rt),
    .flush    (flush),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .dv       (u_if)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_hi"}, hi, 32'd0);
    chk({tag, "_lo"}, lo, 32'd0);
    chk({tag, "_begin"}, 32'(u_if.div_begin), 32'd0);
    chk({tag, "_signed"}, 32'(u_if.div_signed), 32'd0);
    chk({tag, "_op1"}, u_if.div_op1, 32'd0);
    chk({tag, "_op2"}, u_if.div_op2, 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask
  // entered and left at a negedge; leaves DUT in DONE with the DIV still presented
  task automatic do_div(input logic sgn, input logic [31:0] a, b, q, r, input int lat);
    ex_valid = 1'b1; ex_op = sgn ? OP_DIV : OP_DIVU; ex_rs = a; ex_rt = b;
    #1 chk("t0_stall", 32'(stall), 32'd1);
    chk("t0_begin", 32'(u_if.div_begin), 32'd0);
    @(negedge clk);
    chk("t1_begin", 32'(u_if.div_begin), 32'd1);
    chk("t1_op1", u_if.div_op1, a);
    chk("t1_op2", u_if.div_op2, b);
    chk("t1_signed", 32'(u_if.div_signed), 32'(sgn));
    chk("t1_stall", 32'(stall), 32'd1);
    ex_rs = ~a; ex_rt = ~b;
    repeat (lat - 1) @(negedge clk);
    chk("td_begin", 32'(u_if.div_begin), 32'd1);
    chk("td_stall", 32'(stall), 32'd1);
    chk("td_op1", u_if.div_op1, a);
    chk("td_hi_held", hi, exp_hi);
    chk("td_lo_held", lo, exp_lo);
    u_if.div_end = 1'b1; u_if.div_result = q; u_if.div_remainder = r;
    @(negedge clk);
    u_if.div_end = 1'b0; u_if.div_result = '0; u_if.div_remainder = '0;
    exp_hi = r; exp_lo = q;
    chk("done_hi", hi, exp_hi);
    chk("done_lo", lo, exp_lo);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_begin", 32'(u_if.div_begin), 32'd0);
    chk("done_op1", u_if.div_op1, a);
    chk("done_op2", u_if.div_op2, b);
    chk("done_signed", 32'(u_if.div_signed), 32'(sgn));
  endtask
  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = OP_NONE; ex_rs = '0; ex_rt = '0; flush = 1'b0;
    u_if.div_end = 1'b0; u_if.div_result = '0; u_if.div_remainder = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 34);
    ex_valid = 1'b0;
    @(negedge clk);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 6);
    ex_valid = 1'b0;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_MTHI; ex_rs = 32'h1234_5678;
    #1 chk("mthi_stall", 32'(stall), 32'd0);
    @(negedge clk);
    exp_hi = 32'h1234_5678;
    chk("mthi_hi", hi, exp_hi);
    chk("mthi_begin", 32'(u_if.div_begin), 32'd0);
    ex_op = OP_MTLO; ex_rs = 32'hCAFE_F00D;
    #1 chk("mtlo_stall", 32'(stall), 32'd0);
    @(negedge clk);
    exp_lo = 32'hCAFE_F00D;
    chk("mtlo_lo", lo, exp_lo);
    chk("mtlo_hi_kept", hi, exp_hi);
    chk("mtlo_begin", 32'(u_if.div_begin), 32'd0);
    ex_op = OP_MTHI; ex_rs = 32'hFFFF_0000; flush = 1'b1;
    #1 chk("mthi_flush_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("mthi_flush_hi", hi, exp_hi);
    flush = 1'b0; ex_op = 3'd7; ex_rs = 32'h5555_5555;
    #1 chk("op7_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("op7_begin", 32'(u_if.div_begin), 32'd0);
    chk("op7_hi", hi, exp_hi);
    chk("op7_lo", lo, exp_lo);
    ex_op = OP_DIV; ex_rs = 32'd50; ex_rt = 32'd5;
    #1 chk("fl_t0_stall", 32'(stall), 32'd1);
    repeat (10) @(negedge clk);
    chk("fl_t10_begin", 32'(u_if.div_begin), 32'd1);
    flush = 1'b1; u_if.div_end = 1'b1; u_if.div_result = 32'hDEAD; u_if.div_remainder = 32'hBEEF;
    #1 chk("fl_t10_stall", 32'(stall), 32'd1);
    @(negedge clk);
    flush = 1'b0; u_if.div_end = 1'b0; ex_valid = 1'b0;
    #1 chk("fl_t11_stall", 32'(stall), 32'd0);
    chk("fl_t11_begin", 32'(u_if.div_begin), 32'd0);
    chk("fl_t11_hi", hi, exp_hi);
    chk("fl_t11_lo", lo, exp_lo);
    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 3);
    ex_valid = 1'b0;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs = 32'd1; ex_rt = 32'd1;
    repeat (3) @(negedge clk);
    chk("pre_rst_begin", 32'(u_if.div_begin), 32'd1);
    rst = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    chk_reset("mid_rst");
    rst = 1'b0; exp_hi = '0; exp_lo = '0;
    do_div(1'b1, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5);
    ex_valid = 1'b0;
    @(negedge clk);
    do_div(1'b1, 32'd20, 32'd3, 32'd6, 32'd2, 4);
    ex_rs = 32'h8000_0000; ex_rt = 32'hFFFF_FFFF;
    #1 chk("b2b_done_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("b2b_td2_begin", 32'(u_if.div_begin), 32'd0);
    chk("b2b_td2_stall", 32'(stall), 32'd1);
    chk("b2b_td2_op1", u_if.div_op1, 32'd20);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 34);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("end_stall", 32'(stall), 32'd0);
    chk("end_begin", 32'(u_if.div_begin), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Issue/retire controller sitting directly upstream of `divider`, in the EX stage of the CPU pipeline.
- Accepts DIV/DIVU/MTHI/MTLO from EX and latches the operands.
- Drives the divider handshake and holds the pipeline stalled while the divide runs.
- Owns the architectural HI/LO registers: quotient goes to LO, remainder to HI.

## Interface
Parameters:
- `W`, 32, datapath width. Must equal the divider width.

Ports (clock and reset are one clock domain; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_op`  in  3  operation: 0 NONE, 1 DIV, 2 DIVU, 3 MTHI, 4 MTLO, 5–7 treated as NONE.
- `ex_rs`  in  W  dividend, or MTHI/MTLO source.
- `ex_rt`  in  W  divisor.
- `flush`  in  1  exception/cancel of the EX instruction, including one already in progress.
- `stall`  out  1  combinational; holds IF–EX.
- `hi`  out  W  HI register.
- `lo`  out  W  LO register.
- `div_begin`  out  1  registered; to the divider.
- `div_signed`  out  1  registered; to the divider.
- `div_op1`  out  W  registered; to the divider.
- `div_op2`  out  W  registered; to the divider.
- `div_result`  in  W  quotient from the divider.
- `div_remainder`  in  W  remainder from the divider.
- `div_end`  in  1  one-cycle completion pulse from the divider.

## Operation
State machine:
- IDLE
  - `ex_valid & (op==DIV|DIVU) & !flush`: latch `div_op1<=ex_rs`, `div_op2<=ex_rt`, `div_signed<=(op==DIV)`; go to BUSY.
  - `ex_valid & op==MTHI & !flush`: `hi<=ex_rs`. No stall.
  - `ex_valid & op==MTLO & !flush`: `lo<=ex_rs`. No stall.
- BUSY
  - `div_begin=1` in every BUSY cycle; it is a registered decode of the state.
  - `div_end & !flush`: `lo<=div_result`, `hi<=div_remainder`; go to DONE.
  - `flush` (wins over a simultaneous `div_end`): go to IDLE; HI/LO unchanged.
- DONE
  - One cycle. `stall=0` so the stalled DIV retires. No new issue accepted this cycle. Go to IDLE.

Stall and operand rules:
- `stall = (IDLE & ex_valid & div-op & !flush) | BUSY`.
- `div_op1`, `div_op2` and `div_signed` stay constant from issue through DONE. The divider computes the remainder sign combinationally from live operands, so changing them earlier corrupts the result.
- `div_begin` is low in the cycle after `div_end`. The divider restarts if `div_begin` stays high, so this is mandatory.

Arithmetic:
- No arithmetic in this block. Divide-by-zero writes whatever the divider returns; no trap.

Reset values:
- `hi=0`, `lo=0`.
- `div_begin=0`, `div_signed=0`, `div_op1=0`, `div_op2=0`.
- State IDLE, `stall=0`.
- Reset mid-divide abandons the operation; the divider clears because `div_begin` falls.

## Timing
- T0: IDLE, DIV presented; `stall=1` combinationally.
- T1: BUSY, `div_begin=1`.
- Divider asserts `div_end` about 34 cycles after `div_begin` rises. The block never counts cycles; it waits on `div_end` alone.
- Td: `div_end` sampled.
- Td+1: DONE; `hi`/`lo` show the new values, `stall=0`, `div_begin=0`.
- Td+2: IDLE; a new DIV can issue this cycle, so the earliest re-issue is Td+2.
- MTHI/MTLO: new value visible on `hi`/`lo` the cycle after issue.
- Flush in BUSY: `div_begin=0` and `stall=0` on the next cycle.

## Structure
- Shared package `cpu_pkg`:
  - `hilo_op_t` with the 3-bit encodings above.
  - `hdc_state_t` {IDLE, BUSY, DONE}.
- `divider` is instantiated beside this block at EX level, not inside it.
- One natural sub-module: `hilo_regs` (HI/LO with two write ports, where the divide-complete write and the MT write are mutually exclusive by construction).

## Test plan
- Signed DIV, rs=7, rt=0xFFFFFFFE (-2) -> `lo=0xFFFFFFFD`, `hi=0x00000001`; `stall` high T0 to Td, low at DONE.
- DIVU, rs=0xFFFFFFFF, rt=0x10 -> `lo=0x0FFFFFFF`, `hi=0xF`; `div_signed=0` throughout; operands stable until DONE.
- MTHI 0x12345678, then MTLO 0xCAFEF00D on consecutive cycles -> each visible the next cycle; `stall` never asserted; `div_begin` stays 0.
- DIV, then `flush` at T10 -> `div_begin=0` and `stall=0` at T11; `hi`/`lo` keep prior values. A following DIVU 100/7 yields `lo=14`, `hi=2`.
- `rst` asserted mid-BUSY -> next cycle all outputs at reset values and state IDLE. A subsequent DIV of -9/4 yields `lo=0xFFFFFFFE`, `hi=0xFFFFFFFF`.
- Back-to-back DIVs (20/3, then 0x80000000/0xFFFFFFFF signed) -> second `div_begin` rises no earlier than Td+3. Results: `lo=6, hi=2`, then `lo=0x80000000, hi=0`.
